// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-edge logical/arithmetic/compare ops, bit-serial shifts
// with a start/busy/done handshake so the pipeline can stall on long shifts.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         ctrl,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               err
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b1000;

    typedef enum logic {IDLE, SHIFT} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             ovf;
        logic             err;
    } rsp_t;

    state_t             state, state_n;
    rsp_t               rsp, rsp_n, op_rsp;
    logic               done_n;
    logic [WIDTH-1:0]   acc, acc_n, acc_sh;
    logic [SHAMT_W-1:0] cnt, cnt_n;
    logic               left, left_n;
    logic               is_shift;
    logic [WIDTH-1:0]   sum, diff;

    assign sum    = a + b;
    assign diff   = a - b;
    assign acc_sh = left ? (acc << 1) : (acc >> 1);

    // Single-edge op decode; illegal codes collapse to a zero result with err set.
    always_comb begin
        op_rsp   = '0;
        is_shift = 1'b0;
        case (ctrl)
            OP_AND: op_rsp.result = a & b;
            OP_OR:  op_rsp.result = a | b;
            OP_ADD: begin
                op_rsp.result = sum;
                op_rsp.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_rsp.result = diff;
                op_rsp.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: op_rsp.result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL, OP_SRL: begin
                op_rsp.result = b;
                is_shift      = 1'b1;
            end
            default: op_rsp.err = 1'b1;
        endcase
        op_rsp.zero = (op_rsp.result == '0);
    end

    always_comb begin
        state_n = state;
        rsp_n   = rsp;
        done_n  = 1'b0;
        acc_n   = acc;
        cnt_n   = cnt;
        left_n  = left;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        acc_n   = b;
                        cnt_n   = shamt;
                        left_n  = (ctrl == OP_SLL);
                        state_n = SHIFT;
                    end else begin
                        rsp_n  = op_rsp;
                        done_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                acc_n = acc_sh;
                cnt_n = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    rsp_n.result = acc_sh;
                    rsp_n.zero   = (acc_sh == '0);
                    rsp_n.ovf    = 1'b0;
                    rsp_n.err    = 1'b0;
                    done_n       = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rsp   <= '{result: '0, zero: 1'b1, ovf: 1'b0, err: 1'b0};
            done  <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            left  <= 1'b0;
        end else begin
            state <= state_n;
            rsp   <= rsp_n;
            done  <= done_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            left  <= left_n;
        end
    end

    assign busy   = (state == SHIFT);
    assign result = rsp.result;
    assign zero   = rsp.zero;
    assign ovf    = rsp.ovf;
    assign err    = rsp.err;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, multi-cycle shift corner cases,
// and random ops scored against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  ctrl = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0]  shamt = '0;
    logic        busy, done, zero, ovf, err;
    logic [31:0] result;

    int nchk = 0;
    int nerr = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .a(a), .b(b),
        .shamt(shamt), .busy(busy), .done(done), .result(result), .zero(zero),
        .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z, o, e;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z, o, e;
    } vec_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    // Model works on the mathematical values: wide signed arithmetic, whole shifts.
    function automatic exp_t ref_op(logic [3:0] c, logic [31:0] x, logic [31:0] y, logic [4:0] sh);
        exp_t   r;
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r = '{res: 32'd0, z: 1'b0, o: 1'b0, e: 1'b0, lat: 0};
        case (c)
            4'b0000: r.res = x & y;
            4'b0001: r.res = x | y;
            4'b0010: begin s = sx + sy; r.res = s[31:0]; r.o = (s > SMAX) || (s < SMIN); end
            4'b0110: begin s = sx - sy; r.res = s[31:0]; r.o = (s > SMAX) || (s < SMIN); end
            4'b0111: r.res = (sx < sy) ? 32'd1 : 32'd0;
            4'b0100: begin r.res = y << sh; r.lat = int'(sh); end
            4'b1000: begin r.res = y >> sh; r.lat = int'(sh); end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 32'd0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request for one edge, then scramble inputs (they may change freely).
    task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
        ctrl = c; a = x; b = y; shamt = sh; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ctrl = 4'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    endtask

    // Edges after acceptance until done; busy must stay high meanwhile.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string tag, input logic [3:0] c, input logic [31:0] x,
                                 input logic [31:0] y, input logic [4:0] sh);
        exp_t e;
        int   lat;
        bit   bok;
        e = ref_op(c, x, y, sh);
        issue(c, x, y, sh);
        wait_done(lat, bok);
        check({tag, ".lat"}, 64'(lat), 64'(e.lat));
        check({tag, ".busy"}, 64'(bok), 64'd1);
        check({tag, ".res"}, {32'd0, result}, {32'd0, e.res});
        check({tag, ".flags"}, {61'd0, zero, ovf, err}, {61'd0, e.z, e.o, e.e});
        @(posedge clk); #1;
        check({tag, ".pulse"}, {63'd0, done}, 64'd0);
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{4'b0010, 32'd5,          32'd7,          5'd0, 32'd12,         1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0110, 32'd7,          32'd7,          5'd0, 32'd0,          1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 32'h7FFF_FFFF,  32'd1,          5'd0, 32'h8000_0000,  1'b0, 1'b1, 1'b0};
        tbl[3]  = '{4'b0111, 32'hFFFF_FFFF,  32'd1,          5'd0, 32'd1,          1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0111, 32'h8000_0000,  32'h7FFF_FFFF,  5'd0, 32'd1,          1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'b0111, 32'd1,          32'hFFFF_FFFF,  5'd0, 32'd0,          1'b1, 1'b0, 1'b0};
        tbl[6]  = '{4'b0110, 32'h8000_0000,  32'd1,          5'd0, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0};
        tbl[7]  = '{4'b0000, 32'hF0F0_1234,  32'h0FF0_FF00,  5'd0, 32'h00F0_1200,  1'b0, 1'b0, 1'b0};
        tbl[8]  = '{4'b0001, 32'h1200_0000,  32'h0000_0034,  5'd0, 32'h1200_0034,  1'b0, 1'b0, 1'b0};
        tbl[9]  = '{4'b1111, 32'd9,          32'd9,          5'd0, 32'd0,          1'b1, 1'b0, 1'b1};
        tbl[10] = '{4'b0011, 32'd9,          32'd9,          5'd0, 32'd0,          1'b1, 1'b0, 1'b1};
        tbl[11] = '{4'b0000, 32'hFFFF_FFFF,  32'd0,          5'd0, 32'd0,          1'b1, 1'b0, 1'b0};
        tbl[12] = '{4'b0100, 32'd0,          32'h0000_ABCD,  5'd0, 32'h0000_ABCD,  1'b0, 1'b0, 1'b0};
        tbl[13] = '{4'b1000, 32'd0,          32'h8000_0000,  5'd0, 32'h8000_0000,  1'b0, 1'b0, 1'b0};

        // Reset state
        #12;
        check("rst.busy_done", {62'd0, busy, done}, 64'd0);
        check("rst.result", {32'd0, result}, 64'd0);
        check("rst.flags", {61'd0, zero, ovf, err}, 64'b100);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Table applied back-to-back with start held high
        start = 1'b1;
        for (int i = 0; i < 14; i++) begin
            ctrl = tbl[i].c; a = tbl[i].a; b = tbl[i].b; shamt = tbl[i].sh;
            @(posedge clk); #1;
            check($sformatf("vec%0d.done", i), {62'd0, busy, done}, 64'b01);
            check($sformatf("vec%0d.res", i), {32'd0, result}, {32'd0, tbl[i].res});
            check($sformatf("vec%0d.flags", i), {61'd0, zero, ovf, err}, {61'd0, tbl[i].z, tbl[i].o, tbl[i].e});
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("b2b.done_clear", {63'd0, done}, 64'd0);
        check("b2b.hold", {32'd0, result}, 64'h8000_0000);

        // Directed shifts
        run_and_check("sll4", 4'b0100, 32'd0, 32'd1, 5'd4);
        run_and_check("srl31", 4'b1000, 32'd0, 32'h8000_0000, 5'd31);

        // Start during a shift is ignored
        begin
            int ndone, dedge;
            logic [31:0] r;
            ndone = 0; dedge = -1; r = '0;
            issue(4'b0100, 32'd0, 32'd3, 5'd6);
            for (int e = 1; e <= 10; e++) begin
                if (e == 3) begin ctrl = 4'b0010; a = 32'd1; b = 32'd1; shamt = 5'd0; start = 1'b1; end
                @(posedge clk); #1;
                start = 1'b0;
                if (done) begin ndone++; dedge = e; r = result; end
            end
            check("ign.ndone", 64'(ndone), 64'd1);
            check("ign.edge", 64'(dedge), 64'd6);
            check("ign.res", {32'd0, r}, 64'd192);
        end

        // Reset mid-shift aborts with no done pulse
        begin
            int ndone;
            ndone = 0;
            issue(4'b1000, 32'd0, 32'hFFFF_0000, 5'd20);
            repeat (4) @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            check("rstmid.busy_done", {62'd0, busy, done}, 64'd0);
            check("rstmid.result", {32'd0, result}, 64'd0);
            @(negedge clk); @(negedge clk); rst_n = 1'b1;
            repeat (25) begin
                @(posedge clk); #1;
                if (done || busy) ndone++;
            end
            check("rstmid.quiet", 64'(ndone), 64'd0);
        end
        run_and_check("post_rst_add", 4'b0010, 32'd2, 32'd3, 5'd0);

        // Random ops against the model
        for (int i = 0; i < 150; i++) begin
            logic [3:0] c;
            logic [4:0] sh;
            int sel;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: c = 4'b0000; 1: c = 4'b0001; 2: c = 4'b0010; 3: c = 4'b0110;
                4: c = 4'b0111; 5: c = 4'b0100; 6: c = 4'b1000;
                default: c = 4'($urandom);
            endcase
            sh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 12));
            run_and_check($sformatf("rnd%0d", i), c, $urandom, $urandom, sh);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
